// File: rtl/muldiv_seq.sv
// Purpose : iterative RV64 M-extension multiply/divide unit beside the execute-stage ULA.
// Latency : 65 cycles start-to-result for MUL/DIV*/REM*; 1 cycle for divide-by-zero, overflow, unsupported op.
// Backpressure: none accepted; holds F/D/E through stall_req while working, kill aborts at any time.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-low reset
//   start, kill      accept request in IDLE / abort anything in flight (kill wins over start)
//   op               funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU, others -> result 0
//   src_a, src_b     rs1 / rs2 operands after forwarding
//   stall_req        hold the front of the pipeline (combinational on start in IDLE)
//   busy             high while iterating
//   result_valid     one-cycle pulse in DONE
//   result           registered result, holds until the next completed operation
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]   cnt;
    logic            is_mul_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    // acc: product accumulator (MUL) or 65-bit partial remainder (divide)
    // opa: multiplicand (shifts left) or divisor magnitude
    // opb: multiplier (shifts right) or dividend that becomes the quotient
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    // ---------------- request decode ----------------
    logic            op_mul;
    logic            op_div;
    logic            op_signed;
    logic            op_rem;
    logic            div_zero;
    logic            div_ovf;
    logic            unsupported;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    always_comb begin
        op_mul      = (op == 3'b000);
        op_div      = op[2];
        op_signed   = op[2] & ~op[0];
        op_rem      = op[1];
        div_zero    = op_div && (src_b == '0);
        div_ovf     = op_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        unsupported = !op_mul && !op_div;
        special     = div_zero || div_ovf || unsupported;
        accept      = (state == S_IDLE) && start && !kill;

        special_res = '0;
        if (div_zero)
            special_res = op_rem ? src_a : '1;
        else if (div_ovf)
            special_res = op_rem ? '0 : src_a;

        // Signed divide works on magnitudes; signs are restored on the last iteration.
        a_mag = (op_signed && src_a[XLEN-1]) ? -src_a : src_a;
        b_mag = (op_signed && src_b[XLEN-1]) ? -src_b : src_b;
    end

    // ---------------- one iteration ----------------
    logic [XLEN-1:0] mul_sum;
    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] final_res;
    logic            last_iter;

    always_comb begin
        mul_sum   = acc[XLEN-1:0] + (opb[0] ? opa : '0);
        // Restoring step: shift next dividend bit into the remainder, try to subtract.
        rem_sh    = {acc, opb[XLEN-1]};
        diff      = rem_sh - {2'b00, opa};
        ge        = ~diff[XLEN+1];
        rem_nxt   = ge ? diff[XLEN:0] : rem_sh[XLEN:0];
        quo_nxt   = {opb[XLEN-2:0], ge};
        last_iter = (cnt == CW'(XLEN-1));

        if (is_mul_q)
            final_res = mul_sum;
        else if (is_rem_q)
            final_res = neg_rem_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        else
            final_res = neg_quo_q ? -quo_nxt : quo_nxt;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = special ? S_DONE : S_RUN;
                S_RUN:  if (last_iter) state_nxt = S_DONE;
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // The IDLE term is combinational so the issuing cycle itself is held.
        stall_req    = ((state == S_IDLE) && start && !kill && reset) || (state == S_RUN);
        busy         = (state == S_RUN);
        result_valid = (state == S_DONE) && !kill;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= '0;
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            result    <= '0;
        end else if (accept) begin
            cnt       <= '0;
            is_mul_q  <= op_mul;
            is_rem_q  <= op_rem;
            neg_quo_q <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_rem_q <= op_signed & src_a[XLEN-1];
            acc       <= '0;
            if (op_mul) begin
                opa <= src_a;
                opb <= src_b;
            end else begin
                opa <= b_mag;
                opb <= a_mag;
            end
            if (special)
                result <= special_res;
        end else if ((state == S_RUN) && !kill) begin
            cnt <= cnt + 1'b1;
            if (is_mul_q) begin
                acc <= {1'b0, mul_sum};
                opa <= opa << 1;
                opb <= opb >> 1;
            end else begin
                acc <= rem_nxt;
                opb <= quo_nxt;
            end
            if (last_iter)
                result <= final_res;
        end
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer attached to the execute stage of the 5-stage RV64 pipeline. It takes M-extension operations that the single-cycle ULA cannot perform and runs them over multiple cycles. It holds the pipeline through a stall request to the hazard unit and returns one registered 64-bit result. The ALUResultE select between ULA and this block is done outside the block.

## Interface
Parameters:
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clock.
- start  in  1  request from execute: operands and op valid this cycle.
- kill  in  1  abort current operation (FlushE-driven); synchronous.
- op  in  3  funct3 encoding.
  - 000 MUL: low 64 bits of product.
  - 100 DIV: signed.
  - 101 DIVU: unsigned.
  - 110 REM: signed.
  - 111 REMU: unsigned.
  - 001, 010, 011: unsupported.
- src_a  in  64  rs1 operand (SrcAE after forwarding).
- src_b  in  64  rs2 operand (WriteDataE after forwarding).
- stall_req  out  1  to hazard unit: hold F/D/E stages.
- busy  out  1  registered; high while in RUN.
- result_valid  out  1  one-cycle pulse; result valid.
- result  out  64  registered result; holds last value until overwritten.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: one iteration per cycle, 6-bit counter cnt.
  - DONE: present result for one cycle.
- IDLE, start=1, kill=0:
  - Latch op and operands; cnt←0.
  - Next state DONE for the special cases below; RUN otherwise.
- RUN:
  - One iteration per cycle; cnt increments each cycle.
  - The iteration with cnt==63 moves the FSM to DONE and writes result.
- DONE: result_valid=1, then IDLE unconditionally; start is ignored in DONE.
- start is ignored in RUN.
- MUL: shift-add over 64 iterations on a 64-bit accumulator. Only the low 64 bits are kept, so signedness is irrelevant.
- DIVU/REMU: restoring division, 64 iterations, 65-bit partial remainder.
- DIV/REM: divide |a| by |b| unsigned, then fix signs.
  - Quotient is negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
- Special cases (IDLE→DONE directly, 1-cycle compute):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = src_a.
  - DIV overflow (a=0x8000_0000_0000_0000, b=−1): result = a; REM result = 0.
  - Unsupported op: result = 0.
- stall_req = (IDLE & start & ~kill) | RUN. It is combinational in the IDLE term so the start cycle itself is stalled.
- Priority:
  - reset=0 overrides everything.
  - kill is next: in any state, next state IDLE, busy=0, no result_valid, result unchanged.
  - start is lowest.
- Reset values: state IDLE, cnt=0, busy=0, result_valid=0, result=0, stall_req=0.

## Timing
- start accepted at cycle T (normal op):
  - stall_req high T..T+64.
  - busy high T+1..T+64.
  - result_valid=1 and stall_req=0 at T+65.
  - Back in IDLE at T+66.
- Special case accepted at T: stall_req=1 at T only; result_valid=1 at T+1; IDLE at T+2.
- At the result_valid cycle stall_req=0, so the instruction advances to M with result muxed into ALUResultE.
- The earliest next start is the cycle after DONE.
- kill during RUN at cycle K: busy=0 and stall_req=0 from K+1.
- kill coincident with start in IDLE: no acceptance; stall_req=0 in that cycle.
- reset low mid-RUN: all outputs return to reset values on the next edge; the operation is discarded.

## Test plan
- Reset held low 2 cycles, then released → all outputs 0, state IDLE; start at T=op MUL, a=7, b=6 → stall_req 1 for T..T+64, result_valid at T+65, result=42.
- MUL a=0xFFFF_FFFF_FFFF_FFFF (−1), b=3 → result=0xFFFF_FFFF_FFFF_FFFD at T+65.
- DIV a=−20, b=3 → result=−6; REM same operands → −2; DIVU a=100, b=7 → 14; REMU → 2; each valid at T+65.
- DIVU b=0, a=5 → result=0xFFFF_FFFF_FFFF_FFFF at T+1; REM b=0, a=−9 → −9; DIV a=0x8000_0000_0000_0000, b=−1 → a, at T+1.
- start MUL at T, kill=1 at T+10 → busy=0 and stall_req=0 at T+11, no result_valid, result keeps the old value; new DIVU 9/2 started at T+12 → 4 at T+77.
- reset driven low at T+30 of a DIV → at T+31 all outputs are reset values and no result_valid follows; start and kill applied together in IDLE → stall_req=0, no busy.
